// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} with a ready flag held while start_i stays high.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     op2_abs_q, op2_abs_d;
  logic                  signed_q, signed_d;
  logic                  op1_neg_q, op1_neg_d;
  logic                  op2_neg_q, op2_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     rem;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;
    // Partial remainder sits one bit above the quotient field of the work register.
    diff    = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, op2_abs_q};
    quo     = work_q[DATA_W-1:0];
    rem     = work_q[2*DATA_W:DATA_W+1];
    quo_fix = (signed_q && (op1_neg_q ^ op2_neg_q)) ? ('0 - quo) : quo;
    rem_fix = (signed_q && op1_neg_q) ? ('0 - rem) : rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    op2_abs_d = op2_abs_q;
    signed_d  = signed_q;
    op1_neg_d = op1_neg_q;
    op2_neg_d = op2_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          signed_d  = signed_div_i;
          op1_neg_d = opdata1_i[DATA_W-1];
          op2_neg_d = opdata2_i[DATA_W-1];
          op2_abs_d = op2_abs;
          cnt_d     = '0;
          work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          state_d   = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end

      ST_BYZERO: begin
        work_d  = '0;
        state_d = ST_END;
      end

      ST_ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ST_FREE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end else begin
          if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_END: begin
        if (!start_i || annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = ST_FREE;
        end else if (!ready_q) begin
          // Only the divide-by-zero path arrives here without a registered result.
          ready_d  = 1'b1;
          result_d = {rem, quo};
        end
      end

      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      op2_abs_q <= '0;
      signed_q  <= 1'b0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      op2_abs_q <= op2_abs_d;
      signed_q  <= signed_d;
      op1_neg_q <= op1_neg_d;
      op2_neg_q <= op2_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level latency/result model
// compared every cycle, plus directed vectors with literal expectations.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference division by plain arithmetic; SV division truncates toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_ph;
  int          m_left;
  logic        m_zero;
  logic [63:0] m_exp;
  logic [63:0] m_res;
  logic        m_ready;

  // Transaction model: result appears 33 edges after acceptance (2 for divide-by-zero).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= M_IDLE; m_left <= 0; m_zero <= 1'b0;
      m_exp <= '0; m_res <= '0; m_ready <= 1'b0;
    end else begin
      case (m_ph)
        M_IDLE: if (start_i && !annul_i) begin
          m_exp  <= ref_div(signed_div_i, opdata1_i, opdata2_i);
          m_zero <= (opdata2_i == 32'd0);
          m_left <= (opdata2_i == 32'd0) ? 2 : 33;
          m_ph   <= M_BUSY;
        end
        M_BUSY: begin
          if (annul_i && !(m_zero && m_left == 2)) begin
            m_ph <= M_IDLE;
          end else if (m_left == 1) begin
            m_ph <= M_DONE; m_ready <= 1'b1; m_res <= m_exp;
          end else begin
            m_left <= m_left - 1;
          end
        end
        M_DONE: if (!start_i || annul_i) begin
          m_ph <= M_IDLE; m_ready <= 1'b0; m_res <= '0;
        end
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
      check("cyc_result", result_o, m_res);
    end
  end

  // Caller is at a negedge; start is asserted immediately so back-to-back starts are exercised.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input bit chg);
    int n = 0;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(negedge clk); n = 1;
    if (chg) begin
      opdata1_i = '0; opdata2_i = '0; signed_div_i = ~s;
    end
    while (!ready_o && n < 60) begin
      @(negedge clk); n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat + 1));
    check({name, "_res"}, result_o, exp);
    @(negedge clk);
    check({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_clr"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    int n;
    repeat (2) @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 1'b0);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 1'b0);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33, 1'b0);
    run_div("divzero",  1'b1, 32'h12345678,   32'd0,          64'd0,                           2,  1'b0);
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},           33, 1'b0);
    run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33, 1'b0);
    run_div("opchg",    1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 1'b1);

    // start together with annul in FREE must not be accepted
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    check("free_annul_ready", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check("free_annul_idle", {63'd0, ready_o}, 64'd0);

    // annul at iteration 10
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    check("annul_noready", {63'd0, seen}, 64'd0);
    run_div("r9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

    // async reset at iteration 20, between edges
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("arst_mid", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("r50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b0);

    // async reset while a result is being held
    opdata1_i = 32'd7; opdata2_i = 32'd2; signed_div_i = 1'b0; start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 60) begin
      @(negedge clk); n++;
    end
    check("held_res", result_o, {32'd1, 32'd3});
    #2 rst = 1'b0;
    #1 check("arst_held", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
